btb_assoc: RTL and testbench

- Parametrised, set-associative branch target buffer for the dual-issue fetch stage.
- Two independent lookup ports, one per fetch slot, each returning its own hit and target with 1-cycle registered latency.
- Per-entry 2-bit saturating direction counter and per-set LRU replacement.
- Single update port driven from branch resolution; synchronous whole-table invalidate on flush.

---
 rtl/btb_assoc_pkg.sv | 19 +
 rtl/btb_way.sv | 82 ++++++++
 rtl/btb_assoc.sv | 236 +++++++++++++++++++++++
 tb/tb_btb_assoc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared constants for the branch target buffer.
//
// Holds the default BTB geometry (BTB_SET_NUM, BTB_WAYS, BTB_IDX_LSB,
// BTB_CNT_WIDTH) and a helper that sizes a way-index field.
// Index and tag widths are derived from these in each module as localparams.
package btb_assoc_pkg;

    localparam int unsigned BTB_PC_WIDTH  = 32;
    localparam int unsigned BTB_SET_NUM   = 64;
    localparam int unsigned BTB_WAYS      = 2;
    localparam int unsigned BTB_IDX_LSB   = 2;
    localparam int unsigned BTB_CNT_WIDTH = 2;

    // Width of a way number; kept at least 1 so a direct-mapped build still has a legal field.
    function automatic int unsigned way_idx_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the set-associative BTB.
//
// Holds per-set valid bit, direction counter, tag and target. Two read ports
// (one per fetch slot) report tag match, counter MSB and stored target. The
// write port reports match / valid / counter for the resolving branch's set
// and performs a write (tag, counter, valid, optional target) when wr_en.
// Valid bits and counters are async-reset; tag and target storage are not.
// flush clears every valid bit and blocks a same-cycle write.
module btb_way
    import btb_assoc_pkg::*;
#(
    parameter  int unsigned PC_WIDTH  = BTB_PC_WIDTH,
    parameter  int unsigned SET_NUM   = BTB_SET_NUM,
    parameter  int unsigned IDX_LSB   = BTB_IDX_LSB,
    parameter  int unsigned CNT_WIDTH = BTB_CNT_WIDTH,
    localparam int unsigned IDX_W     = $clog2(SET_NUM),
    localparam int unsigned TAG_W     = PC_WIDTH - IDX_LSB - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [IDX_W-1:0]     rd_idx_1,
    input  logic [TAG_W-1:0]     rd_tag_1,
    output logic                 rd_match_1,
    output logic                 rd_taken_1,
    output logic [PC_WIDTH-1:0]  rd_tgt_1,
    input  logic [IDX_W-1:0]     rd_idx_2,
    input  logic [TAG_W-1:0]     rd_tag_2,
    output logic                 rd_match_2,
    output logic                 rd_taken_2,
    output logic [PC_WIDTH-1:0]  rd_tgt_2,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    output logic                 wr_match,
    output logic                 wr_valid,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    input  logic                 wr_en,
    input  logic                 wr_tgt_en,
    input  logic [CNT_WIDTH-1:0] wr_cnt_new,
    input  logic [PC_WIDTH-1:0]  wr_tgt
);

    logic [SET_NUM-1:0]   valid_q;
    logic [CNT_WIDTH-1:0] cnt_q [SET_NUM];
    logic [TAG_W-1:0]     tag_q [SET_NUM];
    logic [PC_WIDTH-1:0]  tgt_q [SET_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < int'(SET_NUM); s++) begin
                cnt_q[s] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            cnt_q[wr_idx]   <= wr_cnt_new;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            tag_q[wr_idx] <= wr_tag;
            if (wr_tgt_en) begin
                tgt_q[wr_idx] <= wr_tgt;
            end
        end
    end

    assign rd_match_1 = valid_q[rd_idx_1] && (tag_q[rd_idx_1] == rd_tag_1);
    assign rd_taken_1 = cnt_q[rd_idx_1][CNT_WIDTH-1];
    assign rd_tgt_1   = tgt_q[rd_idx_1];
    assign rd_match_2 = valid_q[rd_idx_2] && (tag_q[rd_idx_2] == rd_tag_2);
    assign rd_taken_2 = cnt_q[rd_idx_2][CNT_WIDTH-1];
    assign rd_tgt_2   = tgt_q[rd_idx_2];

    assign wr_valid = valid_q[wr_idx];
    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_cnt   = cnt_q[wr_idx];

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer for the dual-issue fetch stage.
//
// Ports: clk, rst_n (async active-low); two lookup ports (i_rd_vld_x, i_pc_x
// -> o_hit_x, o_pc_btb_x, one cycle later, registered); one update port from
// branch resolution (i_wr_en, i_wr_taken, i_jmpsrc, i_jmpaddr); i_flush
// invalidates every entry and drops a same-cycle update.
// Holds LRU state, victim selection, hit mux and output registers; storage
// lives in WAYS instances of btb_way.
// Optional: define BTB_BYPASS_EN to let a lookup see a same-cycle update to
// the same tag/index; otherwise the lookup returns pre-update contents.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = BTB_PC_WIDTH,
    parameter int unsigned SET_NUM   = BTB_SET_NUM,
    parameter int unsigned WAYS      = BTB_WAYS,
    parameter int unsigned IDX_LSB   = BTB_IDX_LSB,
    parameter int unsigned CNT_WIDTH = BTB_CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rd_vld_1,
    input  logic [PC_WIDTH-1:0] i_pc_1,
    input  logic                i_rd_vld_2,
    input  logic [PC_WIDTH-1:0] i_pc_2,
    output logic                o_hit_1,
    output logic [PC_WIDTH-1:0] o_pc_btb_1,
    output logic                o_hit_2,
    output logic [PC_WIDTH-1:0] o_pc_btb_2,
    input  logic                i_wr_en,
    input  logic                i_wr_taken,
    input  logic [PC_WIDTH-1:0] i_jmpsrc,
    input  logic [PC_WIDTH-1:0] i_jmpaddr,
    input  logic                i_flush
);

    localparam int unsigned IDX_W = $clog2(SET_NUM);
    localparam int unsigned TAG_W = PC_WIDTH - IDX_LSB - IDX_W;
    localparam int unsigned WAY_W = way_idx_w(WAYS);
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    logic [IDX_W-1:0] rd_idx_1, rd_idx_2, wr_idx;
    logic [TAG_W-1:0] rd_tag_1, rd_tag_2, wr_tag;

    assign rd_idx_1 = i_pc_1[IDX_LSB +: IDX_W];
    assign rd_idx_2 = i_pc_2[IDX_LSB +: IDX_W];
    assign wr_idx   = i_jmpsrc[IDX_LSB +: IDX_W];
    assign rd_tag_1 = i_pc_1[PC_WIDTH-1 -: TAG_W];
    assign rd_tag_2 = i_pc_2[PC_WIDTH-1 -: TAG_W];
    assign wr_tag   = i_jmpsrc[PC_WIDTH-1 -: TAG_W];

    if (IDX_LSB > 0) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^{i_pc_1[IDX_LSB-1:0], i_pc_2[IDX_LSB-1:0],
                                   i_jmpsrc[IDX_LSB-1:0]};
    end

    logic [WAYS-1:0]      m1, t1, m2, t2, wm, wv, wr_en_v;
    logic [PC_WIDTH-1:0]  tg1 [WAYS];
    logic [PC_WIDTH-1:0]  tg2 [WAYS];
    logic [CNT_WIDTH-1:0] wc  [WAYS];
    logic [CNT_WIDTH-1:0] cnt_new;

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        btb_way #(
            .PC_WIDTH  (PC_WIDTH),
            .SET_NUM   (SET_NUM),
            .IDX_LSB   (IDX_LSB),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (i_flush),
            .rd_idx_1   (rd_idx_1),
            .rd_tag_1   (rd_tag_1),
            .rd_match_1 (m1[w]),
            .rd_taken_1 (t1[w]),
            .rd_tgt_1   (tg1[w]),
            .rd_idx_2   (rd_idx_2),
            .rd_tag_2   (rd_tag_2),
            .rd_match_2 (m2[w]),
            .rd_taken_2 (t2[w]),
            .rd_tgt_2   (tg2[w]),
            .wr_idx     (wr_idx),
            .wr_tag     (wr_tag),
            .wr_match   (wm[w]),
            .wr_valid   (wv[w]),
            .wr_cnt     (wc[w]),
            .wr_en      (wr_en_v[w]),
            .wr_tgt_en  (i_wr_taken),
            .wr_cnt_new (cnt_new),
            .wr_tgt     (i_jmpaddr)
        );
    end

    // Update path: find the matching way or pick a victim, compute the new counter.
    logic             upd_hit, inv_found, touch;
    logic [WAY_W-1:0] upd_way, vic_way, lru_vic, touch_way;
    logic [CNT_WIDTH-1:0] cur_cnt;

    always_comb begin
        upd_hit   = 1'b0;
        upd_way   = '0;
        inv_found = 1'b0;
        vic_way   = lru_vic;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (wm[w]) begin
                upd_hit = 1'b1;
                upd_way = WAY_W'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!wv[w]) begin
                inv_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        cur_cnt = wc[upd_way];
        cnt_new = CNT_WEAK;
        if (upd_hit) begin
            cnt_new = cur_cnt;
            if (i_wr_taken && (cur_cnt != '1)) begin
                cnt_new = cur_cnt + CNT_WIDTH'(1);
            end else if (!i_wr_taken && (cur_cnt != '0)) begin
                cnt_new = cur_cnt - CNT_WIDTH'(1);
            end
        end
        touch     = i_wr_en && !i_flush && (upd_hit || i_wr_taken);
        touch_way = upd_hit ? upd_way : vic_way;
        for (int unsigned w = 0; w < WAYS; w++) begin
            wr_en_v[w] = touch && (touch_way == WAY_W'(w));
        end
    end

    // LRU: WAYS=2 stores the LRU way directly; WAYS=4 is a 3-bit tree where
    // bit 0 picks the half holding the victim and bits 1/2 pick within each half.
    if (WAYS == 1) begin : g_no_lru
        assign lru_vic = '0;
    end else begin : g_lru
        localparam int unsigned LRU_W = (WAYS == 4) ? 3 : 1;
        logic [LRU_W-1:0] lru_q [SET_NUM];
        logic [LRU_W-1:0] lru_cur, lru_nxt;

        assign lru_cur = lru_q[wr_idx];

        if (WAYS == 2) begin : g_two
            assign lru_vic = lru_cur[0];
            assign lru_nxt = ~touch_way[0];
        end else begin : g_tree
            assign lru_vic = lru_cur[0] ? {1'b1, lru_cur[2]} : {1'b0, lru_cur[1]};
            always_comb begin
                lru_nxt    = lru_cur;
                lru_nxt[0] = ~touch_way[1];
                if (!touch_way[1]) begin
                    lru_nxt[1] = ~touch_way[0];
                end else begin
                    lru_nxt[2] = ~touch_way[0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < int'(SET_NUM); s++) begin
                    lru_q[s] <= '0;
                end
            end else if (i_flush) begin
                for (int s = 0; s < int'(SET_NUM); s++) begin
                    lru_q[s] <= '0;
                end
            end else if (touch) begin
                lru_q[wr_idx] <= lru_nxt;
            end
        end
    end

    // Lookup path.
    logic                hit_1, hit_2, any_1, any_2, tk_1, tk_2;
    logic [PC_WIDTH-1:0] sel_1, sel_2;

    always_comb begin
        any_1 = 1'b0;
        tk_1  = 1'b0;
        sel_1 = '0;
        any_2 = 1'b0;
        tk_2  = 1'b0;
        sel_2 = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (m1[w]) begin
                any_1 = 1'b1;
                tk_1  = t1[w];
                sel_1 = tg1[w];
            end
            if (m2[w]) begin
                any_2 = 1'b1;
                tk_2  = t2[w];
                sel_2 = tg2[w];
            end
        end
        hit_1 = i_rd_vld_1 && any_1 && tk_1;
        hit_2 = i_rd_vld_2 && any_2 && tk_2;
`ifdef BTB_BYPASS_EN
        if (i_wr_en && !i_flush && (rd_idx_1 == wr_idx) && (rd_tag_1 == wr_tag)) begin
            if (i_wr_taken) begin
                hit_1 = i_rd_vld_1;
                sel_1 = i_jmpaddr;
            end else if (upd_hit) begin
                hit_1 = i_rd_vld_1 && cnt_new[CNT_WIDTH-1];
            end
        end
        if (i_wr_en && !i_flush && (rd_idx_2 == wr_idx) && (rd_tag_2 == wr_tag)) begin
            if (i_wr_taken) begin
                hit_2 = i_rd_vld_2;
                sel_2 = i_jmpaddr;
            end else if (upd_hit) begin
                hit_2 = i_rd_vld_2 && cnt_new[CNT_WIDTH-1];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hit_1    <= 1'b0;
            o_pc_btb_1 <= '0;
            o_hit_2    <= 1'b0;
            o_pc_btb_2 <= '0;
        end else begin
            o_hit_1    <= hit_1;
            o_pc_btb_1 <= hit_1 ? sel_1 : '0;
            o_hit_2    <= hit_2;
            o_pc_btb_2 <= hit_2 ? sel_2 : '0;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (default geometry: 64 sets, 2 ways,
// index = pc[7:2], tag = pc[31:8]). Each step drives one cycle of stimulus,
// pushes the expected lookup results for both ports to per-port queues, and
// pops/compares them once the registered outputs are available.
// Define BTB_BYPASS_EN to build the bench for the bypass variant.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_rd_vld_1, i_rd_vld_2;
    logic [31:0] i_pc_1, i_pc_2;
    logic        o_hit_1, o_hit_2;
    logic [31:0] o_pc_btb_1, o_pc_btb_2;
    logic        i_wr_en, i_wr_taken, i_flush;
    logic [31:0] i_jmpsrc, i_jmpaddr;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    logic [32:0] exp_q1 [$];
    logic [32:0] exp_q2 [$];

    always #5 clk = ~clk;

    btb_assoc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_vld_1 (i_rd_vld_1),
        .i_pc_1     (i_pc_1),
        .i_rd_vld_2 (i_rd_vld_2),
        .i_pc_2     (i_pc_2),
        .o_hit_1    (o_hit_1),
        .o_pc_btb_1 (o_pc_btb_1),
        .o_hit_2    (o_hit_2),
        .o_pc_btb_2 (o_pc_btb_2),
        .i_wr_en    (i_wr_en),
        .i_wr_taken (i_wr_taken),
        .i_jmpsrc   (i_jmpsrc),
        .i_jmpaddr  (i_jmpaddr),
        .i_flush    (i_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive lookups/update/flush, queue expectations, compare after the edge.
    task automatic step(input logic v1, input logic [31:0] p1, input logic eh1,
                        input logic [31:0] et1,
                        input logic v2, input logic [31:0] p2, input logic eh2,
                        input logic [31:0] et2,
                        input logic we, input logic tk, input logic [31:0] src,
                        input logic [31:0] dst, input logic fl);
        logic [32:0] e1, e2;
        step_no++;
        i_rd_vld_1 = v1;  i_pc_1 = p1;
        i_rd_vld_2 = v2;  i_pc_2 = p2;
        i_wr_en    = we;  i_wr_taken = tk;
        i_jmpsrc   = src; i_jmpaddr  = dst;
        i_flush    = fl;
        exp_q1.push_back({eh1, et1});
        exp_q2.push_back({eh2, et2});
        @(posedge clk);
        #1;
        if (exp_q1.size() == 0 || exp_q2.size() == 0) begin
            check($sformatf("s%0d_queue", step_no), 32'd0, 32'd1);
        end else begin
            e1 = exp_q1.pop_front();
            e2 = exp_q2.pop_front();
            check($sformatf("s%0d_hit1", step_no), {31'd0, o_hit_1}, {31'd0, e1[32]});
            check($sformatf("s%0d_tgt1", step_no), o_pc_btb_1, e1[31:0]);
            check($sformatf("s%0d_hit2", step_no), {31'd0, o_hit_2}, {31'd0, e2[32]});
            check($sformatf("s%0d_tgt2", step_no), o_pc_btb_2, e2[31:0]);
        end
    endtask

    // Shorthands: pure update cycle, and a lookup-only cycle.
    task automatic upd(input logic tk, input logic [31:0] src, input logic [31:0] dst);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, tk, src, dst, 1'b0);
    endtask

    task automatic look(input logic [31:0] p1, input logic eh1, input logic [31:0] et1,
                        input logic [31:0] p2, input logic eh2, input logic [31:0] et2);
        step(1'b1, p1, eh1, et1, 1'b1, p2, eh2, et2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_rd_vld_1 = 1'b0; i_pc_1 = '0; i_rd_vld_2 = 1'b0; i_pc_2 = '0;
        i_wr_en = 1'b0; i_wr_taken = 1'b0; i_jmpsrc = '0; i_jmpaddr = '0; i_flush = 1'b0;
        #12;
        check("rst_hit1", {31'd0, o_hit_1}, 32'd0);
        check("rst_tgt1", o_pc_btb_1, 32'd0);
        check("rst_hit2", {31'd0, o_hit_2}, 32'd0);
        check("rst_tgt2", o_pc_btb_2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold lookup misses; allocate 0x100 -> 0x400 (counter 10).
        look(32'h100, 1'b0, 32'h0, 32'h104, 1'b0, 32'h0);
        upd(1'b1, 32'h100, 32'h400);
        look(32'h100, 1'b1, 32'h400, 32'h100, 1'b1, 32'h400);
        // Not-taken drops to 01 -> miss; taken restores 10 -> hit.
        upd(1'b0, 32'h100, 32'h0);
        look(32'h100, 1'b0, 32'h0, 32'h200, 1'b0, 32'h0);
        upd(1'b1, 32'h100, 32'h400);
        look(32'h100, 1'b1, 32'h400, 32'h103, 1'b1, 32'h400);
        // Saturate at 11, one not-taken leaves 10 (still hit, target kept).
        upd(1'b1, 32'h100, 32'h400);
        upd(1'b1, 32'h100, 32'h400);
        upd(1'b0, 32'h100, 32'h0);
        look(32'h100, 1'b1, 32'h400, 32'h0, 1'b0, 32'h0);
        // Not-taken with no match changes nothing.
        upd(1'b0, 32'h700, 32'h0);
        look(32'h700, 1'b0, 32'h0, 32'h100, 1'b1, 32'h400);
        // Second way of set 0; both ports hit different ways, then the same entry.
        upd(1'b1, 32'h200, 32'h800);
        look(32'h100, 1'b1, 32'h400, 32'h200, 1'b1, 32'h800);
        look(32'h200, 1'b1, 32'h800, 32'h200, 1'b1, 32'h800);
        // 0x200 updated last, so 0x300 evicts 0x100.
        upd(1'b1, 32'h300, 32'hC00);
        look(32'h100, 1'b0, 32'h0, 32'h300, 1'b1, 32'hC00);
        look(32'h200, 1'b1, 32'h800, 32'h300, 1'b1, 32'hC00);
        // Lookup with rd_vld low misses even on a valid entry.
        step(1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h800,
             1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        // Flush with a taken update: flush-cycle lookup is pre-flush, then all miss.
        step(1'b1, 32'h200, 1'b1, 32'h800, 1'b1, 32'h300, 1'b1, 32'hC00,
             1'b1, 1'b1, 32'h500, 32'hA00, 1'b1);
        look(32'h200, 1'b0, 32'h0, 32'h500, 1'b0, 32'h0);
        look(32'h300, 1'b0, 32'h0, 32'h100, 1'b0, 32'h0);
        // Same-cycle update/lookup of 0x600.
`ifdef BTB_BYPASS_EN
        step(1'b1, 32'h600, 1'b1, 32'h900, 1'b1, 32'h200, 1'b0, 32'h0,
             1'b1, 1'b1, 32'h600, 32'h900, 1'b0);
`else
        step(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0,
             1'b1, 1'b1, 32'h600, 32'h900, 1'b0);
`endif
        look(32'h600, 1'b1, 32'h900, 32'h601, 1'b1, 32'h900);
        // Same-cycle not-taken (10 -> 01): bypass sees the miss, otherwise stale hit.
`ifdef BTB_BYPASS_EN
        step(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             1'b1, 1'b0, 32'h600, 32'h0, 1'b0);
`else
        step(1'b1, 32'h600, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0,
             1'b1, 1'b0, 32'h600, 32'h0, 1'b0);
`endif
        look(32'h600, 1'b0, 32'h0, 32'h600, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
